// File: rtl/note_sequencer.sv
// Purpose: snapshot a packed song and step through its 4-bit note slots, holding each note for its duration code.
// Latency: start sampled at edge N gives the first note at edge N+2; each leading padding slot adds one cycle.
// Backpressure: pause freezes the note timer while held; stop aborts at once; start is ignored while busy.
// Optional feature: define NOTE_SEQUENCER_LOOP_EN to replay the song forever instead of ending in DONE.
module note_sequencer #(
    parameter int NOTES        = 56,
    parameter int CLK_PER_UNIT = 10_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [4*NOTES-1:0] song_packed,
    input  logic [4*NOTES-1:0] time_continue,
    output logic [3:0]         note,
    output logic               note_valid,
    output logic [5:0]         note_idx,
    output logic               busy,
    output logic               done
);

    localparam int          CW   = $clog2(15 * CLK_PER_UNIT);
    localparam logic [5:0]  LAST = 6'(NOTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t             state, state_nx;
    logic [4*NOTES-1:0] song_r, song_nx;
    logic [4*NOTES-1:0] dur_r, dur_nx;
    logic [5:0]         idx, idx_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [3:0]         note_r, note_nx;
    logic               nv_r, nv_nx;
    logic               advance;

    logic [3:0]         slot_code;
    logic [3:0]         slot_dur;
    logic [3:0]         dur_eff;
    logic [CW-1:0]      reload;

    // Current slot fields from the snapshot, slot 0 in the top nibble, and the timer reload for it.
    always_comb begin
        slot_code = song_r[4*(NOTES-1-int'(idx)) +: 4];
        slot_dur  = dur_r[4*(NOTES-1-int'(idx)) +: 4];
        dur_eff   = (slot_dur == 4'd0) ? 4'd1 : slot_dur;
        reload    = CW'(int'(dur_eff) * CLK_PER_UNIT - 1);
    end

    // Next-state and datapath decisions; stop overrides everything except rst.
    always_comb begin
        state_nx = state;
        song_nx  = song_r;
        dur_nx   = dur_r;
        idx_nx   = idx;
        cnt_nx   = cnt;
        note_nx  = note_r;
        nv_nx    = nv_r;
        advance  = 1'b0;

        if (stop) begin
            state_nx = S_IDLE;
            note_nx  = 4'd0;
            nv_nx    = 1'b0;
            idx_nx   = 6'd0;
            cnt_nx   = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        song_nx  = song_packed;
                        dur_nx   = time_continue;
                        idx_nx   = 6'd0;
                        state_nx = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (slot_code == 4'd15) begin
                        // Padding slot: skip it without touching the note.
                        advance = 1'b1;
                    end else begin
                        note_nx  = (slot_code <= 4'd7) ? slot_code : 4'd0;
                        nv_nx    = (slot_code != 4'd0) && (slot_code <= 4'd7);
                        cnt_nx   = reload;
                        state_nx = S_HOLD;
                    end
                end
                S_HOLD: begin
                    // The FETCH cycle after HOLD is the note's last visible cycle, so HOLD
                    // ends with one count left. A pause seen in that last cycle waits for
                    // the next HOLD, as FETCH ignores pause.
                    if (cnt <= CW'(1)) begin
                        cnt_nx   = '0;
                        advance  = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        cnt_nx = cnt - CW'(1);
                        if (pause) begin
                            state_nx = S_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (!pause) begin
                        state_nx = S_HOLD;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase

            if (advance) begin
                if (idx == LAST) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
                    idx_nx   = 6'd0;
                    state_nx = S_FETCH;
`else
                    state_nx = S_DONE;
                    note_nx  = 4'd0;
                    nv_nx    = 1'b0;
`endif
                end else begin
                    idx_nx = idx + 6'd1;
                end
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            song_r <= '0;
            dur_r  <= '0;
            idx    <= 6'd0;
            cnt    <= '0;
            note_r <= 4'd0;
            nv_r   <= 1'b0;
        end else begin
            state  <= state_nx;
            song_r <= song_nx;
            dur_r  <= dur_nx;
            idx    <= idx_nx;
            cnt    <= cnt_nx;
            note_r <= note_nx;
            nv_r   <= nv_nx;
        end
    end

    assign note       = note_r;
    assign note_valid = nv_r && (state != S_PAUSE);
    assign note_idx   = idx;
    assign busy       = (state == S_FETCH) || (state == S_HOLD) || (state == S_PAUSE);
    assign done       = (state == S_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Purpose: directed self-checking bench for note_sequencer with CLK_PER_UNIT=4.
// Latency: all expected values are fixed cycle offsets from the sampled start edge.
// Backpressure: exercises pause, stop/start collision, start while busy and mid-song reset.
module tb_note_sequencer;

    localparam int NOTES = 56;
    localparam int CPU   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic               pause;
    logic [4*NOTES-1:0] song_packed;
    logic [4*NOTES-1:0] time_continue;
    logic [3:0]         note;
    logic               note_valid;
    logic [5:0]         note_idx;
    logic               busy;
    logic               done;

    logic [3:0]         codes [NOTES];

    int tests = 0;
    int fails = 0;

    note_sequencer #(.NOTES(NOTES), .CLK_PER_UNIT(CPU)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .pause         (pause),
        .song_packed   (song_packed),
        .time_continue (time_continue),
        .note          (note),
        .note_valid    (note_valid),
        .note_idx      (note_idx),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_slot(input int i, input int c, input int d);
        song_packed[4*(NOTES-1-i) +: 4]   = 4'(c);
        time_continue[4*(NOTES-1-i) +: 4] = 4'(d);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic load_begin_song();
        for (int i = 0; i < NOTES; i++) begin
            codes[i] = (i == NOTES - 1) ? 4'd1 : 4'((i % 7) + 1);
            set_slot(i, int'(codes[i]), 5);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        song_packed = '0; time_continue = '0;
        tick(3);
        check("rst_note",  32'(note), 0);
        check("rst_nv",    32'(note_valid), 0);
        check("rst_idx",   32'(note_idx), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        rst = 1'b0;
        tick(1);

        // begin_song: every slot d=5, i.e. 20 cycles per note.
        load_begin_song();
        pulse_start();
        check("fetch_busy", 32'(busy), 1);
        check("fetch_note", 32'(note), 0);
        tick(1);
        for (int i = 0; i < NOTES; i++) begin
            check("slot_note", 32'(note), 32'(codes[i]));
            check("slot_idx",  32'(note_idx), i);
            check("slot_nv",   32'(note_valid), 1);
            if (i == 3) begin
                tick(4);
                pulse_start();
                check("start_ignored_idx", 32'(note_idx), 3);
                tick(14);
            end else begin
                tick(19);
            end
            if (i < NOTES - 1) begin
                check("held_end_note", 32'(note), 32'(codes[i]));
                tick(1);
            end else begin
`ifdef NOTE_SEQUENCER_LOOP_EN
                check("loop_idx",  32'(note_idx), 0);
                check("loop_busy", 32'(busy), 1);
                check("loop_done", 32'(done), 0);
                tick(1);
                check("loop_note", 32'(note), 32'(codes[0]));
                check("loop_done2", 32'(done), 0);
`else
                check("end_done", 32'(done), 1);
                check("end_note", 32'(note), 0);
                check("end_busy", 32'(busy), 0);
                check("end_nv",   32'(note_valid), 0);
                tick(1);
                check("end_done_stays", 32'(done), 1);
`endif
            end
        end

        // mid_song: six padding slots, a rest, then a paused note and edge-case codes.
        song_packed = {NOTES{4'd2}};
        time_continue = {NOTES{4'd1}};
        for (int i = 0; i < 6; i++) set_slot(i, 15, 0);
        set_slot(6, 0, 1);
        set_slot(7, 3, 5);
        set_slot(8, 4, 0);
        set_slot(9, 9, 1);
        set_slot(10, 5, 1);
`ifdef NOTE_SEQUENCER_LOOP_EN
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
`endif
        pulse_start();                          // t=0
        set_slot(7, 6, 5);                      // live bus change must not be heard
        check("restart_done", 32'(done), 0);
        check("restart_idx",  32'(note_idx), 0);
        tick(6);                                // t=6
        check("pad_idx",  32'(note_idx), 6);
        check("pad_note", 32'(note), 0);
        tick(1);                                // t=7
        check("rest_note", 32'(note), 0);
        check("rest_nv",   32'(note_valid), 0);
        check("rest_idx",  32'(note_idx), 6);
        tick(3);                                // t=10
        check("rest_end_note", 32'(note), 0);
        tick(1);                                // t=11
        check("snap_note", 32'(note), 3);
        check("snap_nv",   32'(note_valid), 1);
        check("snap_idx",  32'(note_idx), 7);
        tick(2);                                // t=13
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin      // t=14..23
            tick(1);
            check("pause_nv", 32'(note_valid), 0);
            if (k == 6) begin
                check("pause_idx",  32'(note_idx), 7);
                check("pause_note", 32'(note), 3);
            end
        end
        pause = 1'b0;
        tick(1);                                // t=24
        check("resume_nv",   32'(note_valid), 1);
        check("resume_note", 32'(note), 3);
        tick(16);                               // t=40
        check("paused_len_note", 32'(note), 3);
        tick(1);                                // t=41
        check("d0_note", 32'(note), 4);
        check("d0_idx",  32'(note_idx), 8);
        tick(3);                                // t=44
        check("d0_end_note", 32'(note), 4);
        tick(1);                                // t=45
        check("code9_note", 32'(note), 0);
        check("code9_nv",   32'(note_valid), 0);
        check("code9_idx",  32'(note_idx), 9);
        tick(3);                                // t=48
        check("code9_end_note", 32'(note), 0);
        tick(1);                                // t=49
        check("after9_note", 32'(note), 5);
        check("after9_nv",   32'(note_valid), 1);
        tick(2);

        // stop and start together: stop wins.
        stop = 1'b1; start = 1'b1;
        tick(1);
        stop = 1'b0; start = 1'b0;
        check("stop_busy", 32'(busy), 0);
        check("stop_note", 32'(note), 0);
        check("stop_nv",   32'(note_valid), 0);
        check("stop_idx",  32'(note_idx), 0);
        check("stop_done", 32'(done), 0);
        tick(3);
        check("stop_stays_idle", 32'(busy), 0);

        // Reset in HOLD at slot 20, with start also high.
        load_begin_song();
        pulse_start();
        tick(1);
        tick(20 * 20 + 5);
        check("pre_rst_idx", 32'(note_idx), 20);
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1; start = 1'b1;
        tick(1);
        rst = 1'b0; start = 1'b0;
        check("midrst_note", 32'(note), 0);
        check("midrst_nv",   32'(note_valid), 0);
        check("midrst_idx",  32'(note_idx), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Reader side of the song library. It snapshots the library's packed note and duration buses when playback starts, then steps through the 56 four-bit slots from most-significant to least-significant. For each slot it presents the note code for the slot's duration. It sits between the song library and the tone generator / buzzer driver, and reports progress and completion to the top-level mode FSM.

## Interface
Parameters:
- NOTES, 56, number of 4-bit slots per song (bus width = 4*NOTES).
- CLK_PER_UNIT, 10_000_000, clock cycles per duration unit (0.1 s at 100 MHz).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE or DONE; begins playback from slot 0.
- stop  in  1  level; aborts playback and returns to IDLE.
- pause  in  1  level; freezes playback while high.
- song_packed  in  4*NOTES  note codes; slot 0 = bits [4*NOTES-1 -: 4].
- time_continue  in  4*NOTES  duration codes; same slot ordering.
- note  out  4  current note code (0 = silence); registered.
- note_valid  out  1  high while a playable note (code 1..7) sounds and playback is not paused.
- note_idx  out  6  index of the slot currently held.
- busy  out  1  high in FETCH, HOLD and PAUSE.
- done  out  1  high in DONE until the next start, stop or rst.

## Operation
- Slot codes:
  - 0 is a rest: silent for its duration.
  - 1..7 are scale degrees.
  - 15 is padding: the slot is skipped, consumes 1 FETCH cycle and produces no output change.
  - 8..14 are treated as rests.
- Duration code d gives a hold of max(d,1)*CLK_PER_UNIT cycles, so d=0 is treated as 1.
- Snapshot: on an accepted start, both buses are latched into internal registers. Later changes on song_packed, time_continue or song selection have no effect until the next start.
- States: IDLE, FETCH, HOLD, PAUSE, DONE.
  - IDLE/DONE + start: latch snapshot, idx=0, done=0, go to FETCH.
  - FETCH, slot code 15: if idx==NOTES-1 go to end-of-song; else idx+1 and stay in FETCH.
  - FETCH, any other code: note = code (0 for codes 0 and 8..14); note_valid = (code in 1..7); cnt = max(d,1)*CLK_PER_UNIT-1; go to HOLD.
  - HOLD: cnt decrements each cycle. At cnt==0: if idx==NOTES-1 go to end-of-song; else idx+1 and go to FETCH.
  - HOLD + pause: go to PAUSE. cnt frozen, note held, note_valid=0.
  - PAUSE + !pause: return to HOLD and restore note_valid.
  - End-of-song: go to DONE with note=0, note_valid=0, done=1.
- stop in any state: go to IDLE with note=0, note_valid=0, idx=0, done=0. stop has priority over start and pause in the same cycle.
- start while busy is ignored.
- pause outside HOLD is ignored. A pause asserted during FETCH takes effect in the first HOLD cycle.
- cnt width is $clog2(15*CLK_PER_UNIT) bits. It never wraps, and its reload value never exceeds 15*CLK_PER_UNIT-1.

## Timing
- Reset values: state=IDLE, note=0, note_valid=0, note_idx=0, busy=0, done=0, cnt=0. Snapshot registers are cleared to 0.
- rst mid-playback: outputs return to reset values on the next edge, regardless of other inputs.
- Start-to-sound latency:
  - start sampled at edge N: FETCH is in cycle N+1, and note/note_valid update at edge N+2.
  - Each leading padding slot adds 1 cycle.
- Note length: a non-padding slot's code is visible for max(d,1)*CLK_PER_UNIT cycles: the HOLD cycles plus the following FETCH cycle. Each padding slot that directly follows extends the preceding note by 1 cycle.
- Pause cycles are added on top of the note length.
- stop takes effect at the edge on which it is sampled.

## Configuration
- NOTE_SEQUENCER_LOOP_EN defined: end-of-song sets idx=0 and returns to FETCH instead of DONE. Playback repeats until stop or rst, and done never asserts.
- Undefined: playback ends in DONE as described above.

## Test plan
Bench parameter for all scenarios: CLK_PER_UNIT=4.
- Library begin_song (all d=5), start pulse: note_idx steps 0..55; slot 1 emits note=2 held 20 cycles; after the final slot (code 1), done=1, note=0, busy=0.
- Library mid_song: 6 leading code-15 slots are skipped in 6 cycles total. The first output is note=0 at note_idx=6, then note=3 at note_idx=7.
- Pause held 10 cycles during a 20-cycle note: the note is held 30 cycles total; note_valid=0 for exactly those 10 cycles, and note_idx is unchanged.
- Slot with d=0, code 4: note=4 is held 4 cycles. Slot with code 9: note=0 and note_valid=0 for its duration.
- stop and start asserted in the same cycle mid-song: IDLE next cycle, note=0, idx=0, done=0. Change song_packed during playback: output follows the snapshot only.
- rst asserted in HOLD at note_idx=20: all outputs are 0 on the next edge. With NOTE_SEQUENCER_LOOP_EN, after slot 55 note_idx returns to 0 and done stays 0.
